// File: rtl/tqvp_prng_fifo.sv
// TinyQV peripheral: xoshiro128++ generator feeding a FIFO of precomputed random words.
// Optional build macro PRNG_UO_STREAM_EN streams the FIFO head [31:24] onto uo_out.
module tqvp_prng_fifo #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] SEED0      = 32'h1,
    parameter logic [31:0] SEED1      = 32'h2,
    parameter logic [31:0] SEED2      = 32'h3,
    parameter logic [31:0] SEED3      = 32'h4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [5:0] A_RND    = 6'h00;
    localparam logic [5:0] A_S0     = 6'h04;
    localparam logic [5:0] A_S1     = 6'h08;
    localparam logic [5:0] A_S2     = 6'h0C;
    localparam logic [5:0] A_S3     = 6'h10;
    localparam logic [5:0] A_STATUS = 6'h14;
    localparam logic [5:0] A_CTRL   = 6'h18;

    logic [31:0]   s0, s1, s2, s3;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    level;
    logic          underflow, gen_en, pop_guard;

    wire unused_ui = &{1'b0, ui_in};

    // xoshiro128++ output and next state, purely from current state
    logic [31:0] sum, result, t, n0, n1, n2, n3, n2a, n3a;
    always_comb begin
        sum    = s0 + s3;
        result = {sum[24:0], sum[31:25]} + s0;
        t      = s1 << 9;
        n2a    = s2 ^ s0;
        n3a    = s3 ^ s1;
        n1     = s1 ^ n2a;
        n0     = s0 ^ n3a;
        n2     = n2a ^ t;
        n3     = {n3a[20:0], n3a[31:21]};
    end

    logic empty, full, wr_any, rd_any, rnd_rd, seed_wr, pop, push, stall, uflow_set;
    logic [31:0] status;
    always_comb begin
        empty     = (level == 5'd0);
        full      = (level == 5'(FIFO_DEPTH));
        wr_any    = (data_write_n != 2'b11);
        rd_any    = (data_read_n != 2'b11);
        rnd_rd    = rd_any && (address == A_RND);
        seed_wr   = (data_write_n == 2'b10) &&
                    (address == A_S0 || address == A_S1 || address == A_S2 || address == A_S3);
        pop       = rnd_rd && !pop_guard && !empty;
        stall     = rnd_rd && !pop_guard && empty && gen_en;
        uflow_set = rnd_rd && !pop_guard && empty && !gen_en;
        push      = gen_en && (!full || pop) && !seed_wr;
        status    = {21'd0, underflow, full, empty, 3'd0, level};
    end

    assign data_ready = !stall;

    always_comb begin
        data_out = 32'd0;
        case (address)
            A_RND:    data_out = pop ? mem[rd_ptr] : 32'd0;
            A_STATUS: data_out = status;
            A_CTRL:   data_out = {31'd0, gen_en};
            default:  data_out = 32'd0;
        endcase
    end

`ifdef PRNG_UO_STREAM_EN
    assign uo_out = empty ? 8'd0 : mem[rd_ptr][31:24];
`else
    assign uo_out = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= result;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0        <= SEED0;
            s1        <= SEED1;
            s2        <= SEED2;
            s3        <= SEED3;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= 5'd0;
            underflow <= 1'b0;
            gen_en    <= 1'b1;
            pop_guard <= 1'b0;
        end else begin
            // guard stays up while the host keeps holding the same request
            pop_guard <= pop || (pop_guard && rnd_rd);

            if (uflow_set)
                underflow <= 1'b1;
            else if (wr_any && data_write_n != 2'b00 && address == A_STATUS && data_in[10])
                underflow <= 1'b0;

            if (wr_any && address == A_CTRL)
                gen_en <= data_in[0];

            if (seed_wr) begin
                case (address)
                    A_S0:    s0 <= data_in;
                    A_S1:    s1 <= data_in;
                    A_S2:    s2 <= data_in;
                    default: s3 <= data_in;
                endcase
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= 5'd0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    s0     <= n0;
                    s1     <= n1;
                    s2     <= n2;
                    s3     <= n3;
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)
                    level <= level + 5'd1;
                else if (pop && !push)
                    level <= level - 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_tqvp_prng_fifo.sv
// Directed bench for tqvp_prng_fifo with a scoreboard of expected xoshiro128++ words.
module tb_tqvp_prng_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;

    tqvp_prng_fifo dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference xoshiro128++ sequence from a given state
    task automatic model_fill(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        logic [31:0] x, tt;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            x  = a + d;
            exp_q.push_back({x[24:0], x[31:25]} + a);
            tt = b << 9;
            c  = c ^ a;
            d  = d ^ b;
            b  = b ^ c;
            a  = a ^ d;
            c  = c ^ tt;
            d  = {d[20:0], d[31:21]};
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        #2;
        check("wr_ready", {31'd0, data_ready}, 32'd1);
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic status_is(input string tag, input logic [31:0] expv);
        address = 6'h14;
        #2;
        check(tag, data_out, expv);
    endtask

    // One 32-bit pop of a non-empty FIFO, checked against the scoreboard
    task automatic rd_rnd(input string tag, output logic [31:0] obs);
        logic [31:0] expv;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        address = 6'h00; data_read_n = 2'b10;
        #2;
        check({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
        check(tag, data_out, expv);
        obs = data_out;
        tick();
        data_read_n = 2'b11;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ui_in = 8'h0; address = 6'h0; data_in = 32'h0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        tick(); tick();
        rst_n = 1'b1;
        status_is("reset_status", 32'h100);
        address = 6'h18;
        #1;
        check("reset_ctrl", data_out, 32'h1);
        check("reset_uo", {24'd0, uo_out}, 32'd0);
        model_fill(32'h1, 32'h2, 32'h3, 32'h4);

        repeat (8) tick();
        status_is("fill_status", 32'h204);
`ifndef PRNG_UO_STREAM_EN
        check("uo_tied", {24'd0, uo_out}, 32'd0);
`endif
        rd_rnd("pop0", got);
        check("pop0_lit", got, 32'd641);
        status_is("lvl_after_pop0", 32'h204);
        rd_rnd("pop1", got);
        check("pop1_lit", got, 32'd1573767);
        rd_rnd("pop2", got);
        check("pop2_lit", got, 32'd3222811527);
        status_is("lvl_after_pop2", 32'h204);

        // drain with generator off, then underflow
        wr(6'h18, 32'h0);
        address = 6'h18;
        #1;
        check("ctrl_off", data_out, 32'h0);
        for (int i = 0; i < 4; i++) rd_rnd("drain", got);
        status_is("drained_status", 32'h100);
        address = 6'h00; data_read_n = 2'b10;
        #2;
        check("uflow_ready", {31'd0, data_ready}, 32'd1);
        check("uflow_data", data_out, 32'h0);
        tick();
        data_read_n = 2'b11;
        status_is("uflow_sticky", 32'h500);
        tick();
        status_is("uflow_still", 32'h500);
        wr(6'h14, 32'h400);
        status_is("uflow_clear", 32'h100);

        // re-enable, let it fill, then reseed back-to-back
        wr(6'h18, 32'h1);
        repeat (6) tick();
        status_is("refill_status", 32'h204);
        wr(6'h04, 32'h1);
        status_is("seed0_flush", 32'h100);
        wr(6'h08, 32'h2);
        status_is("seed1_flush", 32'h100);
        wr(6'h0C, 32'h3);
        status_is("seed2_flush", 32'h100);
        wr(6'h10, 32'h4);
        status_is("seed3_flush", 32'h100);
        model_fill(32'h1, 32'h2, 32'h3, 32'h4);

        // read on the cycle right after the final seed write: one stall cycle
        address = 6'h00; data_read_n = 2'b10;
        #1;
        check("stall_ready", {31'd0, data_ready}, 32'd0);
        tick();
        check("stall_done_ready", {31'd0, data_ready}, 32'd1);
        check("stall_done_data", data_out, exp_q.pop_front());
        check("stall_lit", data_out, 32'd641);
        tick();
        data_read_n = 2'b11;
        tick();

        // read held 3 cycles on a full FIFO -> single pop
        repeat (6) tick();
        status_is("hold_pre", 32'h204);
        address = 6'h00; data_read_n = 2'b10;
        #1;
        check("hold_c1", data_out, exp_q.pop_front());
        tick();
        check("hold_c2_data", data_out, 32'h0);
        check("hold_c2_ready", {31'd0, data_ready}, 32'd1);
        tick();
        check("hold_c3_data", data_out, 32'h0);
        check("hold_c3_ready", {31'd0, data_ready}, 32'd1);
        tick();
        data_read_n = 2'b11;
        tick();
        status_is("hold_post", 32'h204);
        rd_rnd("after_hold", got);

        // reset during a stalled read restores SEED defaults
        wr(6'h04, 32'h5);
        address = 6'h00; data_read_n = 2'b10; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_fill(32'h1, 32'h2, 32'h3, 32'h4);
        #1;
        check("rst_stall_ready", {31'd0, data_ready}, 32'd0);
        tick();
        check("rst_refill_ready", {31'd0, data_ready}, 32'd1);
        check("rst_refill_data", data_out, exp_q.pop_front());
        tick();
        data_read_n = 2'b11;
        tick();
        rd_rnd("rst_pop1", got);
        check("rst_pop1_lit", got, 32'd1573767);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
